// File: rtl/lap_stack_ctrl_if.sv
// ---------------------------------------------------------------------------
// lap_stack_ctrl_if
// Bundles the request, memory and display/status signals of lap_stack_ctrl.
//   master : request side + stack memory (drives lap_req, recall_req,
//            clr_req, count_in, mem_rdata; observes everything else)
//   slave  : the controller (drives mem_write, mem_read, mem_wdata,
//            disp_val, disp_valid, depth, full, empty, busy, err)
// Parameters WIDTH/DEPTH must match those of the controller instance.
// ---------------------------------------------------------------------------
interface lap_stack_ctrl_if #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 5
);
    localparam int DW = $clog2(DEPTH + 1);

    logic             lap_req;
    logic             recall_req;
    logic             clr_req;
    logic [WIDTH-1:0] count_in;
    logic [WIDTH-1:0] mem_rdata;
    logic             mem_write;
    logic             mem_read;
    logic [WIDTH-1:0] mem_wdata;
    logic [WIDTH-1:0] disp_val;
    logic             disp_valid;
    logic [DW-1:0]    depth;
    logic             full;
    logic             empty;
    logic             busy;
    logic             err;

    modport master (
        output lap_req, recall_req, clr_req, count_in, mem_rdata,
        input  mem_write, mem_read, mem_wdata, disp_val, disp_valid,
               depth, full, empty, busy, err
    );

    modport slave (
        input  lap_req, recall_req, clr_req, count_in, mem_rdata,
        output mem_write, mem_read, mem_wdata, disp_val, disp_valid,
               depth, full, empty, busy, err
    );
endinterface

// File: rtl/lap_stack_ctrl.sv
// ---------------------------------------------------------------------------
// lap_stack_ctrl
// Sequences the lap-count stack memory: turns one-cycle lap / recall / clear
// requests into legal push/pop strobes, tracks occupancy, and latches each
// recalled value for the display, staying busy HOLD_CYCLES cycles afterwards.
//
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : lap_stack_ctrl_if.slave
//            in : lap_req, recall_req, clr_req, count_in, mem_rdata
//            out: mem_write, mem_read, mem_wdata, disp_val, disp_valid,
//                 depth, full, empty, busy, err
//
// Build option:
//   LAP_CTRL_ERR_STICKY_EN : err is sticky, cleared by rst or an accepted
//                            clr_req. Undefined: err is a one-cycle pulse
//                            in the cycle after the illegal request.
// ---------------------------------------------------------------------------
module lap_stack_ctrl #(
    parameter int DEPTH       = 5,
    parameter int WIDTH       = 12,
    parameter int HOLD_CYCLES = 4
) (
    input logic           clk,
    input logic           rst,
    lap_stack_ctrl_if.slave bus
);
    localparam int DW = $clog2(DEPTH + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PUSH  = 3'd1,
        POP   = 3'd2,
        HOLD  = 3'd3,
        CLEAR = 3'd4
    } state_t;

    state_t           r_state;
    logic [DW-1:0]    r_depth;
    logic [HW-1:0]    r_hold_cnt;
    logic             r_mem_write;
    logic             r_mem_read;
    logic [WIDTH-1:0] r_mem_wdata;
    logic [WIDTH-1:0] r_disp_val;
    logic             r_disp_valid;
    logic             r_err;

    logic w_idle;
    logic w_full;
    logic w_empty;
    logic w_illegal;

    assign w_idle  = (r_state == IDLE);
    assign w_full  = (r_depth == DW'(DEPTH));
    assign w_empty = (r_depth == '0);

    // Only the request that wins priority can be illegal; a clear is never
    // illegal, and a dropped lower-priority lap never raises err.
    assign w_illegal = w_idle && !bus.clr_req &&
                       ((bus.recall_req && w_empty) ||
                        (!bus.recall_req && bus.lap_req && w_full));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_depth      <= '0;
            r_hold_cnt   <= '0;
            r_mem_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_wdata  <= '0;
            r_disp_val   <= '0;
            r_disp_valid <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            // Strobes are registered and default low; a state that needs
            // one in the following cycle sets it explicitly.
            r_mem_write <= 1'b0;
            r_mem_read  <= 1'b0;

`ifdef LAP_CTRL_ERR_STICKY_EN
            if (w_idle && bus.clr_req)
                r_err <= 1'b0;
            else if (w_illegal)
                r_err <= 1'b1;
`else
            r_err <= w_illegal;
`endif

            case (r_state)
                IDLE: begin
                    if (bus.clr_req) begin
                        r_disp_valid <= 1'b0;
                        if (!w_empty) begin
                            r_state    <= CLEAR;
                            r_mem_read <= 1'b1;
                        end
                    end else if (bus.recall_req) begin
                        if (!w_empty) begin
                            r_state    <= POP;
                            r_mem_read <= 1'b1;
                        end
                    end else if (bus.lap_req) begin
                        if (!w_full) begin
                            r_mem_wdata <= bus.count_in;
                            r_state     <= PUSH;
                            r_mem_write <= 1'b1;
                        end
                    end
                end
                PUSH: begin
                    r_depth <= r_depth + DW'(1);
                    r_state <= IDLE;
                end
                POP: begin
                    // mem_rdata still shows the entry being popped this cycle.
                    r_disp_val   <= bus.mem_rdata;
                    r_disp_valid <= 1'b1;
                    r_depth      <= r_depth - DW'(1);
                    r_hold_cnt   <= '0;
                    r_state      <= HOLD;
                end
                HOLD: begin
                    if (r_hold_cnt == HW'(HOLD_CYCLES - 1))
                        r_state <= IDLE;
                    else
                        r_hold_cnt <= r_hold_cnt + HW'(1);
                end
                CLEAR: begin
                    r_depth <= r_depth - DW'(1);
                    // The read issued in this cycle removes the last entry
                    // when depth is 1, so no further strobe is requested.
                    if (r_depth == DW'(1))
                        r_state <= IDLE;
                    else
                        r_mem_read <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.mem_write  = r_mem_write;
    assign bus.mem_read   = r_mem_read;
    assign bus.mem_wdata  = r_mem_wdata;
    assign bus.disp_val   = r_disp_val;
    assign bus.disp_valid = r_disp_valid;
    assign bus.depth      = r_depth;
    assign bus.full       = w_full;
    assign bus.empty      = w_empty;
    assign bus.busy       = !w_idle;
    assign bus.err        = r_err;
endmodule

// File: tb/tb_lap_stack_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lap_stack_ctrl
// Directed plan followed by randomized requests for lap_stack_ctrl. A simple
// stack memory model answers the controller's strobes; expected behaviour
// comes from a queue-based transaction model of the lap stack.
// ---------------------------------------------------------------------------
module tb_lap_stack_ctrl;
    localparam int DEPTH = 5;
    localparam int WIDTH = 12;
    localparam int HOLD  = 4;
    localparam int DW    = $clog2(DEPTH + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lap_stack_ctrl_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    lap_stack_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH), .HOLD_CYCLES(HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Stack memory: combinational top-of-stack, shares rst.
    logic [WIDTH-1:0] mem [DEPTH];
    int               sp = 0;
    always @(posedge clk) begin
        if (rst) sp <= 0;
        else if (bus.mem_write && sp < DEPTH) begin
            mem[sp] <= bus.mem_wdata;
            sp      <= sp + 1;
        end else if (bus.mem_read && sp > 0) sp <= sp - 1;
    end
    assign bus.mem_rdata = (sp > 0) ? mem[sp-1] : '0;

    // Transaction-level reference.
    logic [WIDTH-1:0] ref_q[$];
    logic [WIDTH-1:0] exp_disp = '0;
    logic             exp_dv   = 1'b0;
    logic             exp_errs = 1'b0;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".depth"}, 32'(bus.depth), ref_q.size());
        check({tag, ".full"}, 32'(bus.full), (ref_q.size() == DEPTH) ? 1 : 0);
        check({tag, ".empty"}, 32'(bus.empty), (ref_q.size() == 0) ? 1 : 0);
        check({tag, ".busy"}, 32'(bus.busy), 0);
        check({tag, ".dvalid"}, 32'(bus.disp_valid), 32'(exp_dv));
        check({tag, ".dval"}, 32'(bus.disp_val), 32'(exp_disp));
        check({tag, ".memsp"}, sp, ref_q.size());
    endtask

    // One request cycle followed by a 12-cycle observation window.
    task automatic op(input string tag, input bit lap, input bit rec, input bit clr,
                      input logic [WIDTH-1:0] val, input bit want_inj);
        int nwr = 0, nrd = 0, nbusy = 0, nerr = 0, first_rd = -1, last_rd = -1;
        int e_wr = 0, e_rd = 0, e_busy = 0, inj = -1;
        bit e_illegal = 0, err0 = 0;
        logic [WIDTH-1:0] wd = '0;

        if (clr) begin
            e_rd = ref_q.size(); e_busy = ref_q.size();
            ref_q.delete(); exp_dv = 1'b0; exp_errs = 1'b0;
        end else if (rec) begin
            if (ref_q.size() > 0) begin
                e_rd = 1; e_busy = 1 + HOLD;
                exp_disp = ref_q.pop_back(); exp_dv = 1'b1;
            end else e_illegal = 1;
        end else if (lap) begin
            if (ref_q.size() < DEPTH) begin
                e_wr = 1; e_busy = 1; ref_q.push_back(val);
            end else e_illegal = 1;
        end
        if (e_illegal) exp_errs = 1'b1;
        if (want_inj && e_busy > 1) inj = $urandom_range(0, e_busy - 1);

        @(negedge clk);
        bus.lap_req = lap; bus.recall_req = rec; bus.clr_req = clr; bus.count_in = val;
        @(negedge clk);
        bus.lap_req = 0; bus.recall_req = 0; bus.clr_req = 0;
        bus.count_in = WIDTH'($urandom);
        for (int i = 0; i < 12; i++) begin
            if (bus.mem_write) begin nwr++; wd = bus.mem_wdata; end
            if (bus.mem_read) begin
                nrd++; if (first_rd < 0) first_rd = i; last_rd = i;
            end
            if (bus.busy) nbusy++;
            if (bus.err) begin nerr++; if (i == 0) err0 = 1; end
            // Requests made while the controller is busy must be dropped.
            bus.recall_req = (i == inj); bus.lap_req = (i == inj);
            @(negedge clk);
        end
        bus.recall_req = 0; bus.lap_req = 0;

        check({tag, ".nwr"}, nwr, e_wr);
        check({tag, ".nrd"}, nrd, e_rd);
        check({tag, ".nbusy"}, nbusy, e_busy);
        if (e_wr == 1) check({tag, ".wdata"}, 32'(wd), 32'(val));
        if (nrd > 0) check({tag, ".rdrun"}, last_rd - first_rd + 1, nrd);
        if (e_rd > 0) check({tag, ".rdstart"}, first_rd, 0);
`ifdef LAP_CTRL_ERR_STICKY_EN
        check({tag, ".err"}, 32'(bus.err), 32'(exp_errs));
`else
        check({tag, ".nerr"}, nerr, e_illegal ? 1 : 0);
        check({tag, ".err0"}, 32'(err0), 32'(e_illegal));
`endif
        check_idle_outputs(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.lap_req = 0; bus.recall_req = 0; bus.clr_req = 0; bus.count_in = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst.mem_write", 32'(bus.mem_write), 0);
        check("rst.mem_read", 32'(bus.mem_read), 0);
        check("rst.wdata", 32'(bus.mem_wdata), 0);
        check("rst.err", 32'(bus.err), 0);
        check_idle_outputs("rst");
        rst = 1'b0;

        // Fill the stack, then overflow attempt.
        for (int k = 1; k <= 5; k++) op("fill", 1, 0, 0, WIDTH'(10 * k), 0);
        check("fill.full", 32'(bus.full), 1);
        op("ovf", 1, 0, 0, 12'd60, 0);
        // Recall with a second request injected during HOLD.
        op("rec1", 0, 1, 0, 12'd0, 1);
        check("rec1.val", 32'(bus.disp_val), 50);
        op("rec2", 0, 1, 0, 12'd0, 0);
        // All three requests together with depth 3: only the clear happens.
        op("clr3", 1, 1, 1, 12'd77, 1);
        op("recemp", 0, 1, 0, 12'd0, 0);
        op("lapemp", 1, 0, 0, 12'd0, 0);
        op("clremp", 0, 0, 1, 12'd0, 0);
        op("lapx", 1, 0, 0, 12'd123, 0);
        op("recx", 0, 1, 0, 12'd0, 0);

        // Reset in the middle of a two-entry clear.
        op("pre1", 1, 0, 0, 12'd900, 0);
        op("pre2", 1, 0, 0, 12'd901, 0);
        @(negedge clk);
        bus.clr_req = 1;
        @(negedge clk);
        bus.clr_req = 0;
        check("rstclr.rd_before", 32'(bus.mem_read), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ref_q.delete(); exp_disp = '0; exp_dv = 1'b0; exp_errs = 1'b0;
        check("rstclr.mem_read", 32'(bus.mem_read), 0);
        check("rstclr.mem_write", 32'(bus.mem_write), 0);
        check("rstclr.wdata", 32'(bus.mem_wdata), 0);
        check("rstclr.err", 32'(bus.err), 0);
        check_idle_outputs("rstclr");

        // Randomized traffic, biased toward laps so the stack fills.
        for (int n = 0; n < 60; n++) begin
            int  r;
            bit  l, c, rc;
            r  = $urandom_range(0, 99);
            l  = (r < 55) || ($urandom_range(0, 3) == 0);
            rc = (r >= 45 && r < 85) || ($urandom_range(0, 5) == 0);
            c  = (r >= 90) || ($urandom_range(0, 15) == 0);
            op("rnd", l, rc, c, WIDTH'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/lap_stack_ctrl.md
# lap_stack_ctrl

Controller that sequences the 5-entry, 12-bit lap-count stack memory. Converts single-cycle lap, recall and clear requests into legal push/pop strobes and tracks occupancy so the stack never overflows or underflows. Latches each recalled value for the display path and holds it for a fixed number of cycles. Sits between the button/edge-detect logic and the stack memory in the stopwatch datapath.

## Interface
Parameters:
- DEPTH, 5, stack entries; must match the memory's entry count
- WIDTH, 12, data width of counts
- HOLD_CYCLES, 4, cycles the controller stays busy after a recall (≥1)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, synchronous, active-high
- lap_req  in  1  one-cycle pulse: push current count
- recall_req  in  1  one-cycle pulse: pop top entry to display
- clr_req  in  1  one-cycle pulse: empty the stack
- count_in  in  WIDTH  live count value
- mem_rdata  in  WIDTH  memory top-of-stack output (combinational in memory)
- mem_write  out  1  push strobe to memory
- mem_read  out  1  pop strobe to memory
- mem_wdata  out  WIDTH  data pushed
- disp_val  out  WIDTH  last recalled value
- disp_valid  out  1  disp_val holds a recalled value
- depth  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH
- full  out  1  depth == DEPTH
- empty  out  1  depth == 0
- busy  out  1  state != IDLE
- err  out  1  illegal request flag (see Configuration)

## Operation
- FSM states: IDLE, PUSH, POP, HOLD, CLEAR.
- Requests sampled only in IDLE; requests arriving in any other state are dropped, no error.
- Same-cycle priority in IDLE: clr_req > recall_req > lap_req; lower-priority requests dropped.
- IDLE, lap_req, !full: latch count_in into mem_wdata; go PUSH. PUSH: mem_write=1 for one cycle, depth+1, go IDLE.
- IDLE, lap_req, full: stay IDLE, raise err, no write.
- IDLE, recall_req, !empty: go POP. POP: mem_read=1 for one cycle, disp_val<=mem_rdata, disp_valid<=1, depth-1, go HOLD. HOLD: count HOLD_CYCLES cycles, then IDLE.
- IDLE, recall_req, empty: stay IDLE, raise err, no read.
- IDLE, clr_req, !empty: go CLEAR. CLEAR: mem_read=1 every cycle, depth-1 each cycle; leave to IDLE in the cycle depth reaches 0. disp_valid<=0 on entry.
- IDLE, clr_req, empty: stay IDLE, disp_valid<=0, no error.
- mem_write and mem_read never high in the same cycle; mem_read never issued when depth==0; mem_write never issued when depth==DEPTH.
- disp_val/disp_valid hold until next POP overwrites or clear zeroes disp_valid.

## Timing
- Reset (sync, dominates all): state IDLE, depth 0, mem_write 0, mem_read 0, mem_wdata 0, disp_val 0, disp_valid 0, err 0; full 0, empty 1, busy 0. Memory shares rst; depth 0 matches its empty state.
- Reset mid-PUSH/POP/CLEAR: strobe deasserted the cycle after rst sampled high; no partial state retained.
- Push: lap_req at cycle N -> mem_write at N+1 -> depth updated at N+2.
- Recall: recall_req at N -> mem_read at N+1, disp_val/disp_valid valid at N+2; busy high N+1 through N+1+HOLD_CYCLES; next request accepted at N+2+HOLD_CYCLES.
- Clear with depth d: mem_read high cycles N+1..N+d; IDLE at N+d+1.
- full/empty/busy are combinational decodes of registered state/depth.

## Configuration
- LAP_CTRL_ERR_STICKY_EN defined: err is sticky; set on any illegal request, cleared only by rst or an accepted clr_req (including clear when empty).
- Not defined: err is a one-cycle pulse in the cycle after the illegal request.

## Test plan
- After rst, 5 lap_req pulses with count_in 10,20,30,40,50 spaced 3 cycles -> 5 mem_write pulses with those data, depth 5, full 1.
- 6th lap_req when full -> no mem_write, err asserted (pulse or sticky per macro), depth stays 5.
- recall_req with depth 5, HOLD_CYCLES 4 -> one mem_read, disp_val 50, disp_valid 1, depth 4, busy 5 cycles; recall_req during HOLD ignored.
- recall_req with depth 0 -> no mem_read, err asserted, disp_val unchanged.
- clr_req with depth 3 -> mem_read high exactly 3 consecutive cycles, depth 0, disp_valid 0; clr_req+recall_req+lap_req same cycle -> only clear performed.
- rst asserted during CLEAR with depth 2 -> next cycle mem_read 0, depth 0, all outputs at reset values.
